// File: rtl/nes_cpu_pkg.sv
// Shared CPU types, sizes and the 6502 opcode length table used by fetch.
// Combinational helpers only; no state lives here.
// No handshakes here; the flow-control rules belong to the fetch unit.
package nes_cpu_pkg;

    localparam int MEM_ADDR_SIZE  = 16;
    localparam int BYTE           = 8;
    localparam int MAX_INSTR_SIZE = 3;
    localparam logic [MEM_ADDR_SIZE-1:0] BOOT_ADDR = 16'h0000;
    localparam logic [BYTE-1:0]          NOP       = 8'hEA;

    typedef enum logic [1:0] {
        FETCH_OPCODE,
        FETCH_ABS_B0,
        FETCH_ABS_B1,
        FETCH_INSTR_READY
    } fetch_state_t;

    typedef struct packed {
        logic [BYTE-1:0]          opcode;
        logic [BYTE-1:0]          byte1;
        logic [BYTE-1:0]          byte2;
        logic [1:0]               len;
        logic [MEM_ADDR_SIZE-1:0] pc;
    } fetch_instr_t;

    // Documented MOS 6502 lengths; everything else, BRK included, is one byte.
    function automatic logic [1:0] opcode_len(input logic [BYTE-1:0] op);
        logic [1:0] len;
        len = 2'd1;
        case (op)
            8'h0D, 8'h0E, 8'h19, 8'h1D, 8'h1E, 8'h20, 8'h2C, 8'h2D,
            8'h2E, 8'h39, 8'h3D, 8'h3E, 8'h4C, 8'h4D, 8'h4E, 8'h59,
            8'h5D, 8'h5E, 8'h6C, 8'h6D, 8'h6E, 8'h79, 8'h7D, 8'h7E,
            8'h8C, 8'h8D, 8'h8E, 8'h99, 8'h9D, 8'hAC, 8'hAD, 8'hAE,
            8'hB9, 8'hBC, 8'hBD, 8'hBE, 8'hCC, 8'hCD, 8'hCE, 8'hD9,
            8'hDD, 8'hDE, 8'hEC, 8'hED, 8'hEE, 8'hF9, 8'hFD, 8'hFE:
                len = 2'd3;
            8'h01, 8'h05, 8'h06, 8'h09, 8'h10, 8'h11, 8'h15, 8'h16,
            8'h21, 8'h24, 8'h25, 8'h26, 8'h29, 8'h30, 8'h31, 8'h35,
            8'h36, 8'h41, 8'h45, 8'h46, 8'h49, 8'h50, 8'h51, 8'h55,
            8'h56, 8'h61, 8'h65, 8'h66, 8'h69, 8'h70, 8'h71, 8'h75,
            8'h76, 8'h81, 8'h84, 8'h85, 8'h86, 8'h90, 8'h91, 8'h94,
            8'h95, 8'h96, 8'hA0, 8'hA1, 8'hA2, 8'hA4, 8'hA5, 8'hA6,
            8'hA9, 8'hB0, 8'hB1, 8'hB4, 8'hB5, 8'hB6, 8'hC0, 8'hC1,
            8'hC4, 8'hC5, 8'hC6, 8'hC9, 8'hD0, 8'hD1, 8'hD5, 8'hD6,
            8'hE0, 8'hE1, 8'hE4, 8'hE5, 8'hE6, 8'hE9, 8'hF0, 8'hF1,
            8'hF5, 8'hF6:
                len = 2'd2;
            default: len = 2'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/nes_instr_length_decoder.sv
// Maps an opcode byte to its instruction length (1..3).
// Purely combinational, zero cycles.
// No flow control.
module nes_instr_length_decoder
    import nes_cpu_pkg::*;
(
    input  logic [BYTE-1:0] opcode_i,
    output logic [1:0]      len_o
);

    assign len_o = opcode_len(opcode_i);

endmodule

// File: rtl/nes_fetch_unit.sv
// 6502 fetch: reads one byte per beat and assembles 1-3 byte instructions for decode.
// Latency 1+len cycles per instruction with no wait states and decode always ready.
// Stalls on mem_ready_i low; while decode withholds ready the instruction holds and memory is idle.
module nes_fetch_unit
    import nes_cpu_pkg::*;
(
    input  logic                           clk_i,
    input  logic                           rst_ni,
    output logic                           mem_req_o,
    output logic [MEM_ADDR_SIZE-1:0]       mem_addr_o,
    input  logic                           mem_ready_i,
    input  logic [BYTE-1:0]                mem_rdata_i,
    output logic                           instr_valid_o,
    input  logic                           instr_ready_i,
    output logic [MAX_INSTR_SIZE*BYTE-1:0] instr_o,
    output logic [1:0]                     instr_len_o,
    output logic [MEM_ADDR_SIZE-1:0]       instr_pc_o,
    input  logic                           redirect_i,
    input  logic [MEM_ADDR_SIZE-1:0]       redirect_pc_i
);

    fetch_state_t             state_q, state_d;
    logic [MEM_ADDR_SIZE-1:0] pc_q, pc_d;
    fetch_instr_t             instr_q, instr_d;
    logic [1:0]               dec_len;
    logic                     beat;

    nes_instr_length_decoder u_len_dec (
        .opcode_i (mem_rdata_i),
        .len_o    (dec_len)
    );

    assign mem_req_o     = (state_q != FETCH_INSTR_READY);
    assign beat          = mem_req_o && mem_ready_i;
    assign instr_valid_o = (state_q == FETCH_INSTR_READY);
    assign instr_o       = {instr_q.byte2, instr_q.byte1, instr_q.opcode};
    assign instr_len_o   = instr_q.len;
    assign instr_pc_o    = instr_q.pc;

    // Operand addresses are offsets from the opcode PC, wrapping at 64K.
    always_comb begin
        mem_addr_o = pc_q;
        case (state_q)
            FETCH_ABS_B0: mem_addr_o = pc_q + MEM_ADDR_SIZE'(1);
            FETCH_ABS_B1: mem_addr_o = pc_q + MEM_ADDR_SIZE'(2);
            default:      mem_addr_o = pc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        // A redirect overrides any capture or handoff happening this cycle.
        if (redirect_i) begin
            state_d = FETCH_OPCODE;
            pc_d    = redirect_pc_i;
        end else begin
            case (state_q)
                FETCH_OPCODE: begin
                    if (beat) begin
                        instr_d.opcode = mem_rdata_i;
                        instr_d.byte1  = '0;
                        instr_d.byte2  = '0;
                        instr_d.len    = dec_len;
                        instr_d.pc     = pc_q;
                        state_d        = (dec_len >= 2'd2) ? FETCH_ABS_B0 : FETCH_INSTR_READY;
                    end
                end
                FETCH_ABS_B0: begin
                    if (beat) begin
                        instr_d.byte1 = mem_rdata_i;
                        state_d       = (instr_q.len == 2'd3) ? FETCH_ABS_B1 : FETCH_INSTR_READY;
                    end
                end
                FETCH_ABS_B1: begin
                    if (beat) begin
                        instr_d.byte2 = mem_rdata_i;
                        state_d       = FETCH_INSTR_READY;
                    end
                end
                FETCH_INSTR_READY: begin
                    if (instr_ready_i) begin
                        pc_d    = pc_q + MEM_ADDR_SIZE'(instr_q.len);
                        state_d = FETCH_OPCODE;
                    end
                end
                default: state_d = FETCH_OPCODE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FETCH_OPCODE;
            pc_q    <= BOOT_ADDR;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

endmodule

// File: tb/tb_nes_fetch_unit.sv
// Bench for nes_fetch_unit: directed scenarios plus randomized traffic scored
// against an instruction-level model of the program in memory.
module tb_nes_fetch_unit;
    import nes_cpu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic        mem_ready_i;
    logic [7:0]  mem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [23:0] instr_o;
    logic [1:0]  instr_len_o;
    logic [15:0] instr_pc_o;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;

    logic [7:0]  dec_op;
    logic [1:0]  dec_len;

    logic [7:0]  mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;

    localparam logic [7:0] OPS3 [48] = '{
        8'h0D, 8'h0E, 8'h19, 8'h1D, 8'h1E, 8'h20, 8'h2C, 8'h2D, 8'h2E, 8'h39, 8'h3D, 8'h3E,
        8'h4C, 8'h4D, 8'h4E, 8'h59, 8'h5D, 8'h5E, 8'h6C, 8'h6D, 8'h6E, 8'h79, 8'h7D, 8'h7E,
        8'h8C, 8'h8D, 8'h8E, 8'h99, 8'h9D, 8'hAC, 8'hAD, 8'hAE, 8'hB9, 8'hBC, 8'hBD, 8'hBE,
        8'hCC, 8'hCD, 8'hCE, 8'hD9, 8'hDD, 8'hDE, 8'hEC, 8'hED, 8'hEE, 8'hF9, 8'hFD, 8'hFE};

    localparam logic [7:0] OPS2 [74] = '{
        8'h01, 8'h05, 8'h06, 8'h09, 8'h10, 8'h11, 8'h15, 8'h16, 8'h21, 8'h24, 8'h25, 8'h26,
        8'h29, 8'h30, 8'h31, 8'h35, 8'h36, 8'h41, 8'h45, 8'h46, 8'h49, 8'h50, 8'h51, 8'h55,
        8'h56, 8'h61, 8'h65, 8'h66, 8'h69, 8'h70, 8'h71, 8'h75, 8'h76, 8'h81, 8'h84, 8'h85,
        8'h86, 8'h90, 8'h91, 8'h94, 8'h95, 8'h96, 8'hA0, 8'hA1, 8'hA2, 8'hA4, 8'hA5, 8'hA6,
        8'hA9, 8'hB0, 8'hB1, 8'hB4, 8'hB5, 8'hB6, 8'hC0, 8'hC1, 8'hC4, 8'hC5, 8'hC6, 8'hC9,
        8'hD0, 8'hD1, 8'hD5, 8'hD6, 8'hE0, 8'hE1, 8'hE4, 8'hE5, 8'hE6, 8'hE9, 8'hF0, 8'hF1,
        8'hF5, 8'hF6};

    always #5 clk_i = ~clk_i;

    assign mem_rdata_i = mem[mem_addr_o];

    nes_fetch_unit dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ready_i   (mem_ready_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_len_o   (instr_len_o),
        .instr_pc_o    (instr_pc_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    nes_instr_length_decoder u_dec (
        .opcode_i (dec_op),
        .len_o    (dec_len)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_len(input logic [7:0] op);
        foreach (OPS3[i]) if (OPS3[i] == op) return 2'd3;
        foreach (OPS2[i]) if (OPS2[i] == op) return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic [23:0] ref_word(input logic [15:0] p);
        logic [23:0] w;
        logic [15:0] p1;
        logic [15:0] p2;
        logic [1:0]  n;
        p1 = p + 16'd1;
        p2 = p + 16'd2;
        n  = ref_len(mem[p]);
        w  = {16'h0000, mem[p]};
        if (n >= 2'd2) w[15:8]  = mem[p1];
        if (n == 2'd3) w[23:16] = mem[p2];
        return w;
    endfunction

    // Scoreboard: the expected instruction stream is the program walked from the
    // boot/redirect address, one instruction at a time.
    logic [15:0] exp_pc;
    logic        hold_q;
    logic [23:0] hold_instr;
    logic [1:0]  hold_len;
    logic [15:0] hold_pc;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            exp_pc <= BOOT_ADDR;
            hold_q <= 1'b0;
        end else begin
            if (hold_q) begin
                check_eq("hold_valid", instr_valid_o, 1'b1);
                check_eq("hold_instr", instr_o, hold_instr);
                check_eq("hold_len",   instr_len_o, hold_len);
                check_eq("hold_pc",    instr_pc_o, hold_pc);
            end
            hold_q     <= instr_valid_o && !instr_ready_i && !redirect_i;
            hold_instr <= instr_o;
            hold_len   <= instr_len_o;
            hold_pc    <= instr_pc_o;
            if (instr_valid_o && instr_ready_i) begin
                check_eq("sb_pc",    instr_pc_o, exp_pc);
                check_eq("sb_len",   instr_len_o, ref_len(mem[exp_pc]));
                check_eq("sb_instr", instr_o, ref_word(exp_pc));
                n_acc  <= n_acc + 1;
                exp_pc <= exp_pc + 16'(ref_len(mem[exp_pc]));
            end
            if (redirect_i) exp_pc <= redirect_pc_i;
        end
    end

    task automatic reset_assert();
        @(posedge clk_i); #1;
        rst_ni        = 1'b0;
        redirect_i    = 1'b0;
        mem_ready_i   = 1'b1;
        instr_ready_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic reset_release();
        redirect_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    task automatic load_stream();
        mem[16'h0000] = 8'hEA; mem[16'h0001] = 8'hA9; mem[16'h0002] = 8'h05;
        mem[16'h0003] = 8'hAD; mem[16'h0004] = 8'h34; mem[16'h0005] = 8'h12;
    endtask

    initial begin
        int vcyc[$];
        int acc0;

        rst_ni        = 1'b1;
        mem_ready_i   = 1'b1;
        instr_ready_i = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 16'h0000;
        dec_op        = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        for (int i = 0; i < 256; i++) begin
            dec_op = 8'(i);
            #1;
            check_eq($sformatf("len_tbl_%02h", i), dec_len, ref_len(8'(i)));
        end

        // Reset with a redirect held high: the redirect must be ignored.
        #2 rst_ni = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 16'h8000;
        load_stream();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_addr",  mem_addr_o, 16'h0000);
        check_eq("rst_req",   mem_req_o, 1'b1);
        check_eq("rst_valid", instr_valid_o, 1'b0);
        check_eq("rst_instr", instr_o, 24'h0);
        check_eq("rst_len",   instr_len_o, 2'd0);
        check_eq("rst_pc",    instr_pc_o, 16'h0000);

        // Stream at full rate.
        reset_release();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk_i);
            if (c == 0) check_eq("str_addr0", mem_addr_o, 16'h0000);
            if (instr_valid_o) vcyc.push_back(c);
            if (c == 1) begin
                check_eq("str_i0", instr_o, 24'h0000EA);
                check_eq("str_l0", instr_len_o, 2'd1);
                check_eq("str_p0", instr_pc_o, 16'h0000);
            end
            if (c == 4) begin
                check_eq("str_i1", instr_o, 24'h0005A9);
                check_eq("str_l1", instr_len_o, 2'd2);
                check_eq("str_p1", instr_pc_o, 16'h0001);
            end
            if (c == 8) begin
                check_eq("str_i2", instr_o, 24'h1234AD);
                check_eq("str_l2", instr_len_o, 2'd3);
                check_eq("str_p2", instr_pc_o, 16'h0003);
            end
            @(posedge clk_i); #1;
        end
        check_eq("str_nvalid", vcyc.size(), 3);
        if (vcyc.size() == 3) begin
            check_eq("str_vcyc0", vcyc[0], 1);
            check_eq("str_vcyc1", vcyc[1], 4);
            check_eq("str_vcyc2", vcyc[2], 8);
        end

        // Wait states on the operand read, then decode backpressure on LDA abs.
        reset_assert();
        reset_release();
        for (int c = 0; c < 18; c++) begin
            mem_ready_i   = !(c >= 3 && c <= 5);
            instr_ready_i = !(c >= 11 && c <= 15);
            @(negedge clk_i);
            if (c >= 3 && c <= 5) begin
                check_eq("ws_addr",  mem_addr_o, 16'h0002);
                check_eq("ws_req",   mem_req_o, 1'b1);
                check_eq("ws_valid", instr_valid_o, 1'b0);
            end
            if (c == 7) begin
                check_eq("ws_valid7", instr_valid_o, 1'b1);
                check_eq("ws_instr",  instr_o, 24'h0005A9);
                check_eq("ws_pc",     instr_pc_o, 16'h0001);
            end
            if (c >= 11 && c <= 15) begin
                check_eq("bp_valid", instr_valid_o, 1'b1);
                check_eq("bp_instr", instr_o, 24'h1234AD);
                check_eq("bp_req",   mem_req_o, 1'b0);
                check_eq("bp_pc",    instr_pc_o, 16'h0003);
            end
            if (c == 17) begin
                check_eq("bp_next_addr", mem_addr_o, 16'h0006);
                check_eq("bp_next_req",  mem_req_o, 1'b1);
            end
            @(posedge clk_i); #1;
        end
        mem_ready_i   = 1'b1;
        instr_ready_i = 1'b1;

        // Redirect during the second operand read, then redirect with a handshake.
        reset_assert();
        mem[16'h8000] = 8'hA9;
        mem[16'h8001] = 8'h77;
        reset_release();
        for (int c = 0; c < 14; c++) begin
            redirect_i    = (c == 7) || (c == 10);
            redirect_pc_i = 16'h8000;
            @(negedge clk_i);
            if (c == 7) check_eq("rd_b1_addr", mem_addr_o, 16'h0005);
            if (c == 8) begin
                check_eq("rd_addr",  mem_addr_o, 16'h8000);
                check_eq("rd_valid", instr_valid_o, 1'b0);
                check_eq("rd_req",   mem_req_o, 1'b1);
            end
            if (c == 10) begin
                check_eq("rd_first_valid", instr_valid_o, 1'b1);
                check_eq("rd_first_pc",    instr_pc_o, 16'h8000);
                check_eq("rd_first_instr", instr_o, 24'h0077A9);
            end
            if (c == 11) begin
                check_eq("rdhs_addr",  mem_addr_o, 16'h8000);
                check_eq("rdhs_valid", instr_valid_o, 1'b0);
            end
            if (c == 13) check_eq("rdhs_pc", instr_pc_o, 16'h8000);
            @(posedge clk_i); #1;
        end
        redirect_i = 1'b0;

        // Instruction straddling the top of the address space.
        reset_assert();
        mem[16'hFFFE] = 8'hAD;
        mem[16'hFFFF] = 8'h34;
        mem[16'h0000] = 8'h12;
        mem[16'h0001] = 8'hEA;
        reset_release();
        for (int c = 0; c < 6; c++) begin
            redirect_i    = (c == 0);
            redirect_pc_i = 16'hFFFE;
            @(negedge clk_i);
            if (c == 1) begin
                check_eq("wr_addr1",  mem_addr_o, 16'hFFFE);
                check_eq("wr_drop",   instr_valid_o, 1'b0);
            end
            if (c == 2) check_eq("wr_addr2", mem_addr_o, 16'hFFFF);
            if (c == 3) check_eq("wr_addr3", mem_addr_o, 16'h0000);
            if (c == 4) begin
                check_eq("wr_valid", instr_valid_o, 1'b1);
                check_eq("wr_instr", instr_o, 24'h1234AD);
                check_eq("wr_pc",    instr_pc_o, 16'hFFFE);
                check_eq("wr_len",   instr_len_o, 2'd3);
            end
            if (c == 5) check_eq("wr_next", mem_addr_o, 16'h0001);
            @(posedge clk_i); #1;
        end
        redirect_i = 1'b0;

        // Asynchronous reset between clock edges aborts immediately.
        @(negedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        check_eq("arst_addr",  mem_addr_o, 16'h0000);
        check_eq("arst_instr", instr_o, 24'h0);
        check_eq("arst_len",   instr_len_o, 2'd0);
        check_eq("arst_pc",    instr_pc_o, 16'h0000);
        check_eq("arst_req",   mem_req_o, 1'b1);

        // Randomized traffic scored by the monitor.
        reset_assert();
        reset_release();
        acc0 = n_acc;
        for (int c = 0; c < 4000; c++) begin
            mem_ready_i   = ($urandom_range(0, 3) != 0);
            instr_ready_i = ($urandom_range(0, 2) != 0);
            redirect_i    = ($urandom_range(0, 40) == 0);
            redirect_pc_i = ($urandom_range(0, 3) == 0) ? 16'hFFFD + 16'($urandom_range(0, 3))
                                                        : 16'($urandom);
            @(posedge clk_i); #1;
        end
        redirect_i = 1'b0;
        @(negedge clk_i);
        check_eq("rand_progress", 32'((n_acc - acc0) > 200), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
